// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - slot state type and saturating unsigned add shared by the adder stages
package adder_pkg;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // Returns {overflow, sum}; the sum is clamped to 2^width-1. Valid for width 1..32.
  function automatic logic [32:0] sat_add_u(input logic [31:0] a, input logic [31:0] b,
                                            input int unsigned width);
    logic [32:0] s;
    logic [32:0] maxv;
    s    = {1'b0, a} + {1'b0, b};
    maxv = (33'd1 << width) - 33'd1;
    if (s > maxv) begin
      return {1'b1, maxv[31:0]};
    end
    return {1'b0, s[31:0]};
  endfunction

endpackage

// File: rtl/adder_accumulator_if.sv
// rtl/adder_accumulator_if.sv - sample input and batch output handshakes of the accumulator
interface adder_accumulator_if #(
  parameter int DATA_WIDTH = 4,
  parameter int ACC_WIDTH  = 8,
  parameter int CNT_WIDTH  = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH:0]   in_x;
  logic                  out_valid;
  logic                  out_ready;
  logic [ACC_WIDTH-1:0]  out_sum;
  logic [CNT_WIDTH-1:0]  out_count;
  logic                  out_overflow;

  modport master (
    output in_valid, in_x, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_overflow
  );

  modport slave (
    input  in_valid, in_x, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_overflow
  );
endinterface

// File: rtl/adder_sat_add.sv
// rtl/adder_sat_add.sv - combinational saturating add of an input sample into the accumulator
module adder_sat_add
  import adder_pkg::*;
#(
  parameter int ACC_WIDTH = 8,
  parameter int IN_WIDTH  = 5
) (
  input  logic [ACC_WIDTH-1:0] i_a,
  input  logic [IN_WIDTH-1:0]  i_b,
  output logic [ACC_WIDTH-1:0] o_sum,
  output logic                 o_ovf
);

  logic [32:0] w_res;

  assign w_res = sat_add_u(32'(i_a), 32'(i_b), ACC_WIDTH);
  assign o_sum = w_res[ACC_WIDTH-1:0];

  generate
    if (ACC_WIDTH < 32) begin : g_narrow
      logic [31-ACC_WIDTH:0] w_hi;
      // After clamping the bits above ACC_WIDTH are zero; folding them in keeps every bit read.
      assign w_hi  = w_res[31:ACC_WIDTH];
      assign o_ovf = w_res[32] | (|w_hi);
    end else begin : g_full
      assign o_ovf = w_res[32];
    end
  endgenerate

endmodule

// File: rtl/adder_accumulator.sv
// rtl/adder_accumulator.sv - batches NUM_SAMPLES adder results into a saturating total behind a one-entry output slot
module adder_accumulator
  import adder_pkg::*;
#(
  parameter  int DATA_WIDTH  = 4,
  parameter  int NUM_SAMPLES = 8,
  parameter  int ACC_WIDTH   = 8,
  localparam int CNT_WIDTH   = $clog2(NUM_SAMPLES + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                flush,
  adder_accumulator_if.slave  bus
);

  localparam logic [CNT_WIDTH-1:0] LP_LAST = CNT_WIDTH'(NUM_SAMPLES - 1);
  localparam logic [CNT_WIDTH-1:0] LP_FULL = CNT_WIDTH'(NUM_SAMPLES);

  logic [ACC_WIDTH-1:0] r_acc;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_ovf;
  slot_state_e          r_slot;
  logic [ACC_WIDTH-1:0] r_out_sum;
  logic [CNT_WIDTH-1:0] r_out_count;
  logic                 r_out_ovf;

  logic [ACC_WIDTH-1:0] w_add_sum;
  logic                 w_add_ovf;
  logic                 w_in_ready;
  logic                 w_xfer;
  logic                 w_pop;
  logic                 w_slot_free;
  logic                 w_close;
  logic [ACC_WIDTH-1:0] w_acc_nxt;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  logic                 w_ovf_nxt;
  slot_state_e          w_slot_nxt;

  adder_sat_add #(
    .ACC_WIDTH (ACC_WIDTH),
    .IN_WIDTH  (DATA_WIDTH + 1)
  ) u_sat_add (
    .i_a   (r_acc),
    .i_b   (bus.in_x),
    .o_sum (w_add_sum),
    .o_ovf (w_add_ovf)
  );

  assign w_pop       = (r_slot == SLOT_FULL) && bus.out_ready;
  assign w_slot_free = (r_slot == SLOT_EMPTY) || bus.out_ready;
  // Only the sample that would close a batch has to wait for the slot.
  assign w_in_ready  = rst_n && !clear && (w_slot_free || (r_cnt < LP_LAST));
  assign w_xfer      = bus.in_valid && w_in_ready;

  assign w_acc_nxt = w_xfer ? w_add_sum : r_acc;
  assign w_ovf_nxt = r_ovf | (w_xfer & w_add_ovf);
  assign w_cnt_nxt = r_cnt + CNT_WIDTH'(w_xfer);

  assign w_close = !clear && ((w_xfer && (w_cnt_nxt == LP_FULL)) ||
                              (flush && w_slot_free && (w_cnt_nxt != '0)));

  always_comb begin
    w_slot_nxt = r_slot;
    if (clear) begin
      w_slot_nxt = SLOT_EMPTY;
    end else begin
      case (r_slot)
        SLOT_EMPTY: if (w_close) w_slot_nxt = SLOT_FULL;
        SLOT_FULL: begin
          if (w_close)    w_slot_nxt = SLOT_FULL;
          else if (w_pop) w_slot_nxt = SLOT_EMPTY;
        end
        default:        w_slot_nxt = SLOT_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_slot      <= SLOT_EMPTY;
      r_out_sum   <= '0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      r_slot <= w_slot_nxt;
      if (clear) begin
        r_acc <= '0;
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else if (w_close) begin
        r_out_sum   <= w_acc_nxt;
        r_out_count <= w_cnt_nxt;
        r_out_ovf   <= w_ovf_nxt;
        r_acc       <= '0;
        r_cnt       <= '0;
        r_ovf       <= 1'b0;
      end else begin
        r_acc <= w_acc_nxt;
        r_cnt <= w_cnt_nxt;
        r_ovf <= w_ovf_nxt;
      end
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.out_valid    = (r_slot == SLOT_FULL);
  assign bus.out_sum      = r_out_sum;
  assign bus.out_count    = r_out_count;
  assign bus.out_overflow = r_out_ovf;

endmodule

// File: tb/tb_adder_accumulator.sv
// tb/tb_adder_accumulator.sv - scoreboard bench for adder_accumulator (8-bit and 6-bit accumulator instances)
module tb_adder_accumulator;

  typedef struct packed {
    logic [7:0] sum;
    logic [3:0] cnt;
    logic       ovf;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, clear8, flush8, clear6, flush6;

  adder_accumulator_if #(.DATA_WIDTH(4), .ACC_WIDTH(8), .CNT_WIDTH(4)) bus8 ();
  adder_accumulator_if #(.DATA_WIDTH(4), .ACC_WIDTH(6), .CNT_WIDTH(4)) bus6 ();

  adder_accumulator #(.DATA_WIDTH(4), .NUM_SAMPLES(8), .ACC_WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .clear(clear8), .flush(flush8), .bus(bus8)
  );
  adder_accumulator #(.DATA_WIDTH(4), .NUM_SAMPLES(8), .ACC_WIDTH(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .clear(clear6), .flush(flush6), .bus(bus6)
  );

  exp_t q8[$];
  exp_t q6[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Scoreboard monitors: compare on every accepted output, and check outputs hold while stalled.
  logic       hold8 = 1'b0, clr8_d = 1'b0;
  logic [7:0] sum8_d = '0;
  always @(negedge clk) begin : mon8
    exp_t e;
    if (rst_n && hold8 && !clr8_d) begin
      chk("hold8_valid", 32'(bus8.out_valid), 32'd1);
      chk("hold8_sum", 32'(bus8.out_sum), 32'(sum8_d));
    end
    if (rst_n && bus8.out_valid && bus8.out_ready) begin
      if (q8.size() == 0) begin
        checks++; failures++;
        $display("FAIL out8_unexpected: actual sum=%0d expected no output", bus8.out_sum);
      end else begin
        e = q8.pop_front();
        chk("out8_sum", 32'(bus8.out_sum), 32'(e.sum));
        chk("out8_count", 32'(bus8.out_count), 32'(e.cnt));
        chk("out8_ovf", 32'(bus8.out_overflow), 32'(e.ovf));
      end
    end
    hold8  = rst_n && bus8.out_valid && !bus8.out_ready;
    clr8_d = clear8;
    sum8_d = bus8.out_sum;
  end

  always @(negedge clk) begin : mon6
    exp_t e;
    if (rst_n && bus6.out_valid && bus6.out_ready) begin
      if (q6.size() == 0) begin
        checks++; failures++;
        $display("FAIL out6_unexpected: actual sum=%0d expected no output", bus6.out_sum);
      end else begin
        e = q6.pop_front();
        chk("out6_sum", 32'(bus6.out_sum), 32'(e.sum));
        chk("out6_count", 32'(bus6.out_count), 32'(e.cnt));
        chk("out6_ovf", 32'(bus6.out_overflow), 32'(e.ovf));
      end
    end
  end

  task automatic send8(input logic [4:0] x, input bit want_rdy);
    int n;
    n = 0;
    bus8.in_valid = 1'b1;
    bus8.in_x     = x;
    @(negedge clk);
    if (want_rdy) chk("in8_ready", 32'(bus8.in_ready), 32'd1);
    while (!bus8.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus8.in_ready) begin
      checks++; failures++;
      $display("FAIL send8_timeout: actual in_ready=0 expected 1 within 50 cycles");
    end
    @(posedge clk); #1;
  endtask

  task automatic send6(input logic [4:0] x);
    int n;
    n = 0;
    bus6.in_valid = 1'b1;
    bus6.in_x     = x;
    @(negedge clk);
    while (!bus6.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus6.in_ready) begin
      checks++; failures++;
      $display("FAIL send6_timeout: actual in_ready=0 expected 1 within 50 cycles");
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual time limit reached expected bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; clear8 = 1'b0; flush8 = 1'b0; clear6 = 1'b0; flush6 = 1'b0;
    bus8.in_valid = 1'b0; bus8.in_x = '0; bus8.out_ready = 1'b1;
    bus6.in_valid = 1'b0; bus6.in_x = '0; bus6.out_ready = 1'b1;

    repeat (2) @(posedge clk); #1;
    chk("rst_valid", 32'(bus8.out_valid), 32'd0);
    chk("rst_sum", 32'(bus8.out_sum), 32'd0);
    chk("rst_count", 32'(bus8.out_count), 32'd0);
    chk("rst_ovf", 32'(bus8.out_overflow), 32'd0);
    chk("rst_in_ready", 32'(bus8.in_ready), 32'd0);
    chk("rst6_in_ready", 32'(bus6.in_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(bus8.in_ready), 32'd1);
    @(posedge clk); #1;

    // 1: eight X=10 back to back
    for (int i = 0; i < 8; i++) begin
      if (i == 7) q8.push_back(exp_t'{8'd80, 4'd8, 1'b0});
      send8(5'd10, 1'b1);
    end
    bus8.in_valid = 1'b0;
    @(negedge clk);
    chk("lat_valid", 32'(bus8.out_valid), 32'd1);
    chk("lat_sum", 32'(bus8.out_sum), 32'd80);
    chk("lat_in_ready", 32'(bus8.in_ready), 32'd1);
    @(posedge clk); #1;

    // 2: sixteen X=1 with the sink stalled
    bus8.out_ready = 1'b0;
    q8.push_back(exp_t'{8'd8, 4'd8, 1'b0});
    q8.push_back(exp_t'{8'd8, 4'd8, 1'b0});
    for (int i = 0; i < 15; i++) send8(5'd1, 1'b0);
    bus8.in_valid = 1'b1;
    bus8.in_x     = 5'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(bus8.in_ready), 32'd0);
    end
    @(posedge clk); #1;
    bus8.out_ready = 1'b1;
    send8(5'd1, 1'b1);
    bus8.in_valid = 1'b0;
    @(negedge clk);
    chk("pop_close_valid", 32'(bus8.out_valid), 32'd1);
    @(posedge clk); #1;

    // 3: saturation on the 6-bit instance, then a clean batch
    for (int i = 0; i < 8; i++) begin
      if (i == 7) q6.push_back(exp_t'{8'd63, 4'd8, 1'b1});
      send6(5'd30);
    end
    for (int i = 0; i < 8; i++) begin
      if (i == 7) q6.push_back(exp_t'{8'd8, 4'd8, 1'b0});
      send6(5'd1);
    end
    bus6.in_valid = 1'b0;
    repeat (2) @(posedge clk); #1;

    // 4: flush with a same-cycle sample, then flush with nothing buffered
    for (int i = 0; i < 3; i++) send8(5'd5, 1'b0);
    q8.push_back(exp_t'{8'd17, 4'd4, 1'b0});
    flush8 = 1'b1;
    send8(5'd2, 1'b1);
    bus8.in_valid = 1'b0;
    flush8 = 1'b0;
    @(negedge clk);
    chk("flush_valid", 32'(bus8.out_valid), 32'd1);
    chk("flush_count", 32'(bus8.out_count), 32'd4);
    @(posedge clk); #1;
    flush8 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("empty_flush_valid", 32'(bus8.out_valid), 32'd0);
    end
    @(posedge clk); #1;
    flush8 = 1'b0;

    // 5: clear with a held batch and a partial batch of five
    bus8.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send8(5'd4, 1'b0);
    for (int i = 0; i < 5; i++) send8(5'd7, 1'b0);
    bus8.in_valid = 1'b0;
    @(negedge clk);
    chk("pre_clear_valid", 32'(bus8.out_valid), 32'd1);
    @(posedge clk); #1;
    clear8 = 1'b1;
    bus8.in_valid = 1'b1;
    bus8.in_x     = 5'd9;
    @(negedge clk);
    chk("clear_in_ready", 32'(bus8.in_ready), 32'd0);
    @(posedge clk); #1;
    clear8 = 1'b0;
    bus8.in_valid = 1'b0;
    @(negedge clk);
    chk("clear_valid", 32'(bus8.out_valid), 32'd0);
    chk("clear_keep_sum", 32'(bus8.out_sum), 32'd32);
    chk("clear_keep_count", 32'(bus8.out_count), 32'd8);
    @(posedge clk); #1;
    bus8.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) q8.push_back(exp_t'{8'd24, 4'd8, 1'b0});
      send8(5'd3, 1'b1);
    end
    bus8.in_valid = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;

    // 6: asynchronous reset mid-batch
    for (int i = 0; i < 4; i++) send8(5'd9, 1'b0);
    bus8.in_valid = 1'b0;
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(bus8.out_valid), 32'd0);
    chk("async_rst_sum", 32'(bus8.out_sum), 32'd0);
    chk("async_rst_count", 32'(bus8.out_count), 32'd0);
    chk("async_rst_in_ready", 32'(bus8.in_ready), 32'd0);
    chk("async_rst6_sum", 32'(bus6.out_sum), 32'd0);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) q8.push_back(exp_t'{8'd16, 4'd8, 1'b0});
      send8(5'd2, 1'b1);
    end
    bus8.in_valid = 1'b0;

    repeat (3) @(negedge clk);
    chk("q8_drained", 32'(q8.size()), 32'd0);
    chk("q6_drained", 32'(q6.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
